riscv_mem_arbiter: RTL and testbench

//   Shares the single-ported unified word memory between the multicycle RISC-V core's fetch port and data (lw/sw) port.

---
 rtl/riscv_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for a single-ported synchronous word RAM: one access per grant, 2-cycle cadence.
// Optional ARB_ROUND_ROBIN_EN: contended grants alternate; otherwise the data port always wins.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(DEPTH) << 2;

  state_e            state_q, state_d;
  logic              own_d_q, own_d_d;   // 1 = data port owns the access
  logic              rd_ok_q, rd_ok_d;   // in-range read: pass mem_rdata through
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              pick_d, contend, sel_we, in_rng;
  logic [ADDR_W-1:0] sel_addr;

  assign contend = if_req & d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;  // 0 favours data, 1 favours fetch
  assign pick_d = d_req & (~if_req | ~ptr_q);
`else
  assign pick_d = d_req;
`endif

  assign sel_addr = pick_d ? d_addr : if_addr;
  assign sel_we   = pick_d & d_we;
  assign in_rng   = {1'b0, sel_addr} < ADDR_LIM;

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    rd_ok_d     = rd_ok_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ACCESS: begin
        state_d     = RESP;
        if_rvalid_d = ~own_d_q;
        d_rvalid_d  = own_d_q;
      end
      default: begin
        if (if_req | d_req) begin
          state_d     = ACCESS;
          own_d_d     = pick_d;
          rd_ok_d     = in_rng & ~sel_we;
          if_gnt_d    = ~pick_d;
          d_gnt_d     = pick_d;
          mem_en_d    = in_rng;
          mem_we_d    = in_rng & sel_we;
          mem_addr_d  = sel_addr[AW+1:2];
          mem_wdata_d = sel_we ? d_wdata : '0;
          if (contend) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d = ~ptr_q;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Async reset drops mem_en/mem_we at once so an in-flight write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      rd_ok_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      rd_ok_q     <= rd_ok_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign if_gnt       = if_gnt_q;
  assign d_gnt        = d_gnt_q;
  assign if_rvalid    = if_rvalid_q;
  assign d_rvalid     = d_rvalid_q;
  assign if_rdata     = (if_rvalid_q & rd_ok_q) ? mem_rdata : '0;
  assign d_rdata      = (d_rvalid_q & rd_ok_q) ? mem_rdata : '0;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != IDLE);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: vector table of single accesses plus contention,
// withdrawal, counter saturation and mid-access reset sequences against a sync RAM model.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] a;
    a = v.addr;
    if_req  = ~v.is_d;
    d_req   = v.is_d;
    d_we    = v.is_d & v.we;
    if_addr = a;
    d_addr  = a;
    d_wdata = v.wdata;
    @(posedge clk); #1;
    chk($sformatf("v%0d gnt", i), 32'(v.is_d ? d_gnt : if_gnt), 32'd1);
    chk($sformatf("v%0d gnt_other", i), 32'(v.is_d ? if_gnt : d_gnt), 32'd0);
    chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v.exp_en));
    chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.exp_en & v.we));
    if (v.exp_en) chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(a[11:2]));
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d rvalid", i), 32'(v.is_d ? d_rvalid : if_rvalid), 32'd1);
    chk($sformatf("v%0d rvalid_other", i), 32'(v.is_d ? if_rvalid : d_rvalid), 32'd0);
    chk($sformatf("v%0d rdata", i), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("v%0d rdata_other", i), v.is_d ? if_rdata : d_rdata, 32'd0);
  endtask

  task automatic contend(input int edges, output int ifg, output int dg, output logic [7:0] order);
    ifg = 0; dg = 0; order = '0;
    if_addr = 32'h8; d_addr = 32'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < edges; k++) begin
      @(posedge clk); #1;
      if (if_gnt && d_gnt) chk("both_gnt", 32'd1, 32'd0);
      if (if_rvalid && d_rvalid) chk("both_rvalid", 32'd1, 32'd0);
      if (if_gnt) begin ifg++; order = {order[6:0], 1'b0}; end
      if (d_gnt)  begin dg++;  order = {order[6:0], 1'b1}; end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ifg, dg;
    logic [7:0] order;
    vec_t v;

    //             is_d we  addr           wdata          en  rdata
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0050_0093, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h0050_0093};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0043, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'h0};

    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst gnts", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid}), 32'd0);
    chk("rst cnt", 32'(conflict_cnt), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;
    chk("idle busy", 32'(busy), 32'd0);
    chk("cnt after singles", 32'(conflict_cnt), 32'd0);
    chk("mem[16]", mem[16], 32'hDEAD_BEEF);
    chk("mem[0] untouched by oor write", mem[0], 32'hCAFE_F00D);

    // Contention: 8 edges from IDLE give 4 arbitrations
    contend(8, ifg, dg, order);
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr d_gnts", 32'(dg), 32'd2);
    chk("rr if_gnts", 32'(ifg), 32'd2);
    chk("rr order", 32'(order[3:0]), 32'b1010);
`else
    chk("fp d_gnts", 32'(dg), 32'd4);
    chk("fp if_gnts", 32'(ifg), 32'd0);
    chk("fp order", 32'(order[3:0]), 32'b1111);
`endif
    chk("cnt after contention", 32'(conflict_cnt), 32'd4);
    chk("busy after contention", 32'(busy), 32'd0);

    // Withdrawn request: pulse between edges, never sampled
    d_req = 1'b1; d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'h0BAD_0BAD;
    #3 d_req = 1'b0;
    @(posedge clk); #1;
    chk("withdraw busy", 32'(busy), 32'd0);
    chk("withdraw gnt", 32'(d_gnt), 32'd0);
    @(posedge clk); #1;
    chk("withdraw mem", mem[16], 32'hDEAD_BEEF);

    // Saturation: preload near the top, then 3 contended arbitrations
    force dut.cnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut.cnt_q;
    @(posedge clk); #1;
    chk("cnt preload", 32'(conflict_cnt), 32'h0000_FFFD);
    contend(2, ifg, dg, order);
    chk("cnt FFFE", 32'(conflict_cnt), 32'h0000_FFFE);
    contend(4, ifg, dg, order);
    chk("cnt saturated", 32'(conflict_cnt), 32'h0000_FFFF);

    // Reset asserted in the ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hBADB_AD00;
    @(posedge clk); #1;
    chk("pre-rst mem_we", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_en mid", 32'(mem_en), 32'd0);
    chk("rst outs mid", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, busy}), 32'd0);
    chk("rst cnt mid", 32'(conflict_cnt), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no rvalid after rst", 32'({d_rvalid, if_rvalid, busy}), 32'd0);
    chk("mem[8] kept", mem[8], 32'h0000_0055);
    v = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0055};
    run_vec(20, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
